hermes_route_arbiter: RTL
=========================

HERMES_ROUTE_ARBITER -- requirements
Module: hermes_route_arbiter

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default 32, flit width in bits (minimum 20).
REQ-002 SHALL have parameter ADDRESS, default 16'h0000, local router address: X in [15:8], Y in [7:0].
REQ-003 SHALL have clk_i  input  1  clock, rising edge.
REQ-004 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have req_i  input  [4:0]  routing request per input buffer (index: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4).
REQ-006 SHALL have data_i  input  [4:0][FLIT_SIZE-1:0]  head flit per input buffer.
REQ-007 SHALL have sending_i  input  [4:0]  input buffer is forwarding a packet.
REQ-008 SHALL have req_ack_o  output  [4:0]  one-hot routing grant pulse.
REQ-009 SHALL have out_busy_o  output  [4:0]  output port allocated.
REQ-010 SHALL have out_sel_o  output  [4:0][2:0]  input index driving each output; valid when out_busy_o set.
REQ-011 SHALL have in_sel_o  output  [4:0][2:0]  output index fed by each input; valid when in_active_o set.
REQ-012 SHALL have in_active_o  output  [4:0]  input holds a connection.

Function
REQ-013 SHALL run FSM IDLE -> ARBITRATE -> ROUTE -> GRANT/IDLE; IDLE leaves only when any req_i bit set and not in_active_o for that bit.
REQ-014 ARBITRATE SHALL pick one eligible requester round-robin, search starting at index after last examined requester, wrapping 4 -> 0.
REQ-015 ROUTE SHALL compute XY: tx=data_i[sel][15:8], ty=data_i[sel][7:0]; tx>lx EAST, tx<lx WEST, else ty>ly NORTH, ty<ly SOUTH, else LOCAL; unsigned compare.
REQ-016 ROUTE SHALL go to GRANT if target output free, else back to IDLE with no ack (blocked; requester retried on later rounds).
REQ-017 GRANT SHALL pulse req_ack_o[sel] for exactly one cycle and, same edge, set out_busy_o, out_sel_o, in_sel_o, in_active_o; then IDLE.
REQ-018 Latency: req_ack_o asserted 3 cycles after IDLE samples req_i (uncontended, output free).
REQ-019 Round-robin pointer SHALL advance past the examined requester on both grant and block, so no requester starves.
REQ-020 Each allocated output SHALL track RESERVED -> ACTIVE when sending_i[in] seen high, ACTIVE -> FREE when sending_i[in] low; release takes effect next cycle.
REQ-021 sending_i low while RESERVED SHALL NOT release (buffer raises sending one cycle after ack).
REQ-022 Release and new grant on the same output in the same cycle: release wins that cycle; grant evaluated only against registered busy state.
REQ-023 Multiple outputs MAY be busy concurrently; an input holds at most one connection.
REQ-024 req_i dropped before GRANT SHALL abort the transaction (return to IDLE, no ack).

Reset
REQ-025 On rst_ni low, SHALL asynchronously clear FSM to IDLE, req_ack_o=0, out_busy_o=0, in_active_o=0, out_sel_o=0, in_sel_o=0, RR pointer=0 (EAST first); mid-packet reset drops all connections.

Configuration
REQ-026 With HERMES_ARB_STATS_EN defined, SHALL add outputs grant_cnt_o [31:0] (incremented per GRANT) and block_cnt_o [31:0] (incremented per blocked ROUTE), wrapping at 2^32, reset to 0.
REQ-027 Without HERMES_ARB_STATS_EN, those ports and counters SHALL be absent; other behaviour identical.

Structure
REQ-028 Package hermes_pkg SHALL hold NPORT=5, port_t enum (EAST..LOCAL = 0..4), and output-state typedef (FREE/RESERVED/ACTIVE).
REQ-029 Round-robin selection SHALL be sub-module hermes_rr_arbiter (req vector + pointer in, one-hot grant + index out).

Verification
REQ-030 ADDRESS=16'h0101, req_i[4] with header 16'h0201 -> req_ack_o[4] pulse at +3 cycles, out_sel_o[0]=4, in_sel_o[4]=0.
REQ-031 Header 16'h0101 on WEST -> routed LOCAL: out_sel_o[4]=1.
REQ-032 EAST, NORTH, LOCAL request simultaneously to distinct outputs -> acks in order 0, 2, 4, each 4 cycles apart.
REQ-033 WEST and SOUTH both target EAST -> WEST granted; SOUTH blocked until WEST sending_i falls; SOUTH granted after release.
REQ-034 sending_i held low 5 cycles after ack -> output stays busy; sending_i high then low -> out_busy_o clears next cycle.
REQ-035 rst_ni pulse with 3 outputs busy -> all busy/active cleared immediately, req_ack_o=0; stats counters (if enabled) read 0.

Source files
------------

// File: rtl/hermes_pkg.sv
// Shared types for the Hermes routing arbiter: port indices,
// FSM and output-allocation states, and the XY routing helper.
package hermes_pkg;

    localparam int NPORT = 5;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } port_t;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        RESERVED = 2'd1,
        ACTIVE   = 2'd2
    } out_state_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARBITRATE = 2'd1,
        ROUTE     = 2'd2,
        GRANT     = 2'd3
    } arb_state_t;

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i >= 3'd4) ? 3'd0 : i + 3'd1;
    endfunction

    function automatic port_t xy_route(
        input logic [7:0] tx,
        input logic [7:0] ty,
        input logic [7:0] lx,
        input logic [7:0] ly
    );
        port_t p;
        p = LOCAL;
        unique case (1'b1)
            (tx > lx):              p = EAST;
            (tx < lx):              p = WEST;
            (tx == lx && ty > ly):  p = NORTH;
            (tx == lx && ty < ly):  p = SOUTH;
            default:                p = LOCAL;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hermes_rr_arbiter.sv
// Round-robin pick over the five input requesters, searching
// from ptr_i upward and wrapping LOCAL back to EAST.
module hermes_rr_arbiter
    import hermes_pkg::*;
(
    input  logic [NPORT-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [NPORT-1:0] gnt_o,
    output logic [2:0]       idx_o,
    output logic             valid_o
);

    logic [2:0] idx;
    logic       found;

    always_comb begin
        gnt_o = '0;
        idx_o = ptr_i;
        found = 1'b0;
        idx   = ptr_i;
        for (int k = 0; k < NPORT; k++) begin
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                idx_o      = idx;
                gnt_o[idx] = 1'b1;
            end
            idx = next_idx(idx);
        end
        valid_o = found;
    end

endmodule

// File: rtl/hermes_route_arbiter.sv
// Hermes router arbiter: round-robin selection, XY routing, output tracking.
// Optional grant/block counters when HERMES_ARB_STATS_EN is defined.
module hermes_route_arbiter
    import hermes_pkg::*;
#(
    parameter int          FLIT_SIZE = 32,
    parameter logic [15:0] ADDRESS   = 16'h0000
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
`ifdef HERMES_ARB_STATS_EN
    output logic [31:0]                     grant_cnt_o,
    output logic [31:0]                     block_cnt_o,
`endif
    input  logic [NPORT-1:0]                req_i,
    input  logic [NPORT-1:0][FLIT_SIZE-1:0] data_i,
    input  logic [NPORT-1:0]                sending_i,
    output logic [NPORT-1:0]                req_ack_o,
    output logic [NPORT-1:0]                out_busy_o,
    output logic [NPORT-1:0][2:0]           out_sel_o,
    output logic [NPORT-1:0][2:0]           in_sel_o,
    output logic [NPORT-1:0]                in_active_o
);

    localparam logic [7:0] LX = ADDRESS[15:8];
    localparam logic [7:0] LY = ADDRESS[7:0];

    arb_state_t                 state_q, state_d;
    logic [2:0]                 ptr_q, ptr_d;
    logic [2:0]                 sel_q, sel_d;
    logic [NPORT-1:0]           sel_oh_q, sel_oh_d;
    port_t                      tgt_q, tgt_d;
    logic [NPORT-1:0]           ack_q, ack_d;
    out_state_t [NPORT-1:0]     ost_q, ost_d;
    logic [NPORT-1:0][2:0]      out_sel_q, out_sel_d;
    logic [NPORT-1:0][2:0]      in_sel_q, in_sel_d;

    logic [NPORT-1:0]           act;
    logic [NPORT-1:0]           busy;
    logic [NPORT-1:0]           eligible;
    logic [NPORT-1:0]           rr_gnt;
    logic [2:0]                 rr_idx;
    logic                       rr_valid;
    logic [FLIT_SIZE-1:0]       hdr;
    port_t                      route;
    logic                       do_block;
    logic                       unused_hdr;

    // An input is connected while any allocated output points at it.
    always_comb begin
        act  = '0;
        busy = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (ost_q[o] != FREE) begin
                busy[o]           = 1'b1;
                act[out_sel_q[o]] = 1'b1;
            end
        end
    end

    assign eligible   = req_i & ~act;
    assign hdr        = data_i[sel_q];
    assign unused_hdr = ^hdr[FLIT_SIZE-1:16];
    assign route      = xy_route(hdr[15:8], hdr[7:0], LX, LY);
    assign do_block   = (state_q == ROUTE) && req_i[sel_q]
                      && (ost_q[route] != FREE);

    hermes_rr_arbiter u_rr (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .gnt_o   (rr_gnt),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        sel_oh_d  = sel_oh_q;
        tgt_d     = tgt_q;
        ack_d     = '0;
        ost_d     = ost_q;
        out_sel_d = out_sel_q;
        in_sel_d  = in_sel_q;

        // Reserved outputs wait for the buffer to start sending.
        for (int o = 0; o < NPORT; o++) begin
            unique case (ost_q[o])
                FREE: ;
                RESERVED: begin
                    if (sending_i[out_sel_q[o]]) ost_d[o] = ACTIVE;
                end
                ACTIVE: begin
                    if (!sending_i[out_sel_q[o]]) ost_d[o] = FREE;
                end
                default: ost_d[o] = FREE;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                if (|eligible) state_d = ARBITRATE;
            end
            ARBITRATE: begin
                if (rr_valid) begin
                    sel_d    = rr_idx;
                    sel_oh_d = rr_gnt;
                    ptr_d    = next_idx(rr_idx);
                    state_d  = ROUTE;
                end else begin
                    state_d  = IDLE;
                end
            end
            ROUTE: begin
                tgt_d = route;
                if (!req_i[sel_q] || do_block) begin
                    state_d = IDLE;
                end else begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ack_d            = sel_oh_q;
                ost_d[tgt_q]     = RESERVED;
                out_sel_d[tgt_q] = sel_q;
                in_sel_d[sel_q]  = tgt_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            sel_oh_q  <= '0;
            tgt_q     <= EAST;
            ack_q     <= '0;
            out_sel_q <= '0;
            in_sel_q  <= '0;
            for (int o = 0; o < NPORT; o++) ost_q[o] <= FREE;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            sel_oh_q  <= sel_oh_d;
            tgt_q     <= tgt_d;
            ack_q     <= ack_d;
            out_sel_q <= out_sel_d;
            in_sel_q  <= in_sel_d;
            ost_q     <= ost_d;
        end
    end

    assign req_ack_o   = ack_q;
    assign out_busy_o  = busy;
    assign out_sel_o   = out_sel_q;
    assign in_sel_o    = in_sel_q;
    assign in_active_o = act;

`ifdef HERMES_ARB_STATS_EN
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] block_cnt_q, block_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        block_cnt_d = block_cnt_q;
        if (state_q == GRANT) grant_cnt_d = grant_cnt_q + 32'd1;
        if (do_block)         block_cnt_d = block_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_q <= '0;
            block_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            block_cnt_q <= block_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign block_cnt_o = block_cnt_q;
`endif

endmodule
